ac_sequencer: RTL and testbench
===============================

# ac_sequencer

Multi-cycle instruction sequencer for the accumulator CPU. It drives `op_i`/`flags_i` into the control unit and consumes that unit's control strobes. It owns PC, IR, MDR and the Z/C flag register, and handles the instruction-fetch and data-access handshakes with memory. It commits the decoded strobes to the datapath in a single execute cycle per instruction.

## Interface
- `DATA_W`, 8: memory word width; instruction = `{op[2:0], operand[DATA_W-4:0]}`
- `ADDR_W`, 5: PC/address width; must equal `DATA_W-3`
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset; one clock; asynchronous, active-high
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  write qualifier, valid with `mem_req_o`
- `mem_addr_o`  out  ADDR_W  request address
- `mem_ack_i`  in  1  memory acknowledge
- `mem_rdata_i`  in  DATA_W  read data, valid with `mem_ack_i`
- `op_o`  out  3  `IR[DATA_W-1:DATA_W-3]`, to control unit
- `operand_o`  out  ADDR_W  `IR[ADDR_W-1:0]` (address / LDI immediate)
- `flags_o`  out  2  `{C,Z}`, to control unit (bit0 = Z, bit1 = C)
- `wr_i`, `wm_i`, `jmp_i`, `wf_i`  in  1 each  control-unit strobes
- `alu_z_i`, `alu_c_i`  in  1 each  ALU result flags
- `mdr_o`  out  DATA_W  latched data-read word
- `acc_we_o`  out  1  accumulator write enable
- `pc_o`  out  ADDR_W  current PC
- `halt_o`  out  1  halted (see Configuration)

## Operation
- States: FETCH, DECODE, DATA, EXEC, HALT.
- **FETCH**: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=PC. On `mem_ack_i`, IR<=`mem_rdata_i` and go to DECODE.
- **DECODE**: one cycle with no memory activity.
  - Op 000–011 (ADD/SUB/LDA/STA): go to DATA.
  - Otherwise: go to EXEC.
- **DATA**: `mem_req_o`=1, `mem_addr_o`=operand, `mem_we_o`=`wm_i`.
  - On ack: MDR<=`mem_rdata_i` (reads only; MDR is unchanged on STA), then go to EXEC.
- **EXEC**: single commit cycle.
  - `acc_we_o`=`wr_i`.
  - If `wf_i`: flags<=`{alu_c_i, alu_z_i}`.
  - PC<=`jmp_i` ? operand : PC+1, modulo 2^ADDR_W; PC wraps from all-ones to 0.
  - Next state FETCH.
- `acc_we_o` is 0 outside EXEC. `mem_we_o` is 0 outside DATA. Flags and PC change only in EXEC.
- Handshake:
  - `mem_req_o`, `mem_addr_o` and `mem_we_o` are held stable until the cycle `mem_ack_i` is sampled high.
  - `mem_ack_i` may be high in the first request cycle, giving zero wait states.
  - `mem_ack_i` while `mem_req_o`=0 is ignored.
- JZ/JC use the flags register value as it stood before EXEC. Flags written by an instruction affect the next instruction only.
- Reset:
  - Values: state=FETCH, PC=0, IR=0, MDR=0, flags=0, `halt_o`=0.
  - Combinational outputs during reset: `acc_we_o`=0, `mem_we_o`=0, `mem_req_o`=1 with `mem_addr_o`=0 (FETCH).
  - Reset mid-handshake abandons the transfer; a pending ack is ignored.

## Timing
- Latency, zero-wait memory:
  - ADD/SUB/LDA/STA: 4 cycles.
  - JMP/JZ/JC/LDI: 3 cycles.
- Each memory wait cycle adds 1 cycle to FETCH or DATA.
- `op_o`, `operand_o` and `flags_o` are registered. They are stable from DECODE through EXEC, so control-unit strobes are settled before EXEC.
- The IR update lands on the clock edge that accepts the fetch ack. DECODE is the first cycle with the new `op_o`.

## Configuration
- `AC_SEQ_HALT_EN` defined:
  - A JMP, or a taken JZ/JC, whose target equals its own PC goes to HALT instead of FETCH.
  - In HALT: `halt_o`=1, `mem_req_o`=0, PC is held, and no strobes are committed. HALT is left only by reset.
  - Flag updates in that EXEC still occur.
- Not defined: `halt_o` is tied to 0. The self-jump executes normally and loops in 3 cycles.

## Test plan
- Reset, then zero-wait memory with word 0 = LDA 5 and mem[5]=0x2A:
  - FETCH addr 0, then DATA addr 5 with `mem_we_o`=0.
  - `mdr_o`=0x2A and `acc_we_o`=1 in cycle 4; then FETCH addr 1.
- STA 7 with 2 wait states in DATA:
  - `mem_addr_o`=7 and `mem_we_o`=1 held for 3 cycles.
  - `acc_we_o`=0 throughout; PC=1 after EXEC.
- Flag chain:
  - SUB with `alu_z_i`=1, `alu_c_i`=0 gives `flags_o`=01.
  - Next JZ 3 loads PC=3.
  - A following JC 9 with C=0 gives PC=4.
- PC wrap: JMP 31 to a non-jump instruction at address 31. That instruction's EXEC gives PC=0 and fetch address 0.
- Assert `rst_i` asynchronously mid-DATA while `mem_ack_i`=1:
  - Outputs go to reset values immediately and MDR stays 0.
  - After release, the first request is FETCH addr 0.
- JMP 4 located at address 4:
  - With `AC_SEQ_HALT_EN`: `halt_o`=1 and `mem_req_o`=0 thereafter.
  - Without it: FETCH addr 4 repeats every 3 cycles.

Source files
------------

// File: rtl/ac_sequencer.sv
// ----------------------------------------------------------------------------
// ac_sequencer
//
// Multi-cycle instruction sequencer for the accumulator CPU. It owns the
// program counter, the instruction register, the memory data register and the
// {C,Z} flag register. It runs the fetch and data handshakes with memory, and
// it commits the control-unit strobes once per instruction, in EXEC.
//
// Instruction word: {op[2:0], operand[DATA_W-4:0]}.
// Ops 000..011 (ADD/SUB/LDA/STA) take a data phase. Ops 100..111
// (JMP/JZ/JC/LDI) go straight from DECODE to EXEC.
//
// Ports
//   clk_i, rst_i     clock (rising edge); reset (asynchronous, active-high)
//   mem_req_o        memory request (FETCH and DATA)
//   mem_we_o         write qualifier, valid with mem_req_o
//   mem_addr_o       request address (PC in FETCH, operand in DATA)
//   mem_ack_i        memory acknowledge; ignored while no request is pending
//   mem_rdata_i      read data, valid with mem_ack_i
//   op_o, operand_o  registered IR fields, to the control unit
//   flags_o          registered {C,Z}, to the control unit
//   wr_i, wm_i,      control-unit strobes: accumulator write, memory write,
//   jmp_i, wf_i      jump taken, flag write
//   alu_z_i, alu_c_i ALU result flags
//   mdr_o            latched data-read word
//   acc_we_o         accumulator write enable (EXEC only)
//   pc_o             current PC
//   halt_o           halted indication
//
// Optional feature macro: AC_SEQ_HALT_EN
//   When defined, a taken jump whose target equals its own PC parks the
//   sequencer in HALT until reset. When undefined, halt_o is tied low and a
//   self-jump simply loops.
//
// ADDR_W must equal DATA_W-3, so the operand field is exactly one address.
// ----------------------------------------------------------------------------
module ac_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [2:0]        op_o,
   output logic [ADDR_W-1:0] operand_o,
   output logic [1:0]        flags_o,
   input  logic              wr_i,
   input  logic              wm_i,
   input  logic              jmp_i,
   input  logic              wf_i,
   input  logic              alu_z_i,
   input  logic              alu_c_i,
   output logic [DATA_W-1:0] mdr_o,
   output logic              acc_we_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              halt_o
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_DATA   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [ADDR_W-1:0]   pc_r;
   logic [DATA_W-1:0]   ir_r;
   logic [DATA_W-1:0]   mdr_r;
   logic [1:0]          flags_r;

   logic                ir_load_s;
   logic                mdr_load_s;
   logic                flag_load_s;
   logic                pc_load_s;
   logic [ADDR_W-1:0]   pc_next_s;
   logic [ADDR_W-1:0]   operand_s;

   // IR fields and registered state presented to the control unit.
   assign op_o      = ir_r[DATA_W-1:DATA_W-3];
   assign operand_s = ir_r[ADDR_W-1:0];
   assign operand_o = operand_s;
   assign flags_o   = flags_r;
   assign mdr_o     = mdr_r;
   assign pc_o      = pc_r;

`ifdef AC_SEQ_HALT_EN
   // The halt indication is decoded from the state register.
   assign halt_o = (state_r == ST_HALT);
`else
   // Halt support is not built, so the indication stays low.
   assign halt_o = 1'b0;
`endif

   // State register. HALT can be left only through reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic, memory handshake outputs and EXEC commit strobes.
   always_comb begin
      state_s     = state_r;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = pc_r;
      acc_we_o    = 1'b0;
      ir_load_s   = 1'b0;
      mdr_load_s  = 1'b0;
      flag_load_s = 1'b0;
      pc_load_s   = 1'b0;
      pc_next_s   = pc_r;
      case (state_r)
         ST_FETCH: begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_r;
            if (mem_ack_i) begin
               ir_load_s = 1'b1;
               state_s   = ST_DECODE;
            end else begin
               state_s   = ST_FETCH;
            end
         end
         ST_DECODE: begin
            // op[2] clear selects the four memory-operand instructions.
            if (op_o[2] == 1'b0) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_DATA: begin
            mem_req_o  = 1'b1;
            mem_addr_o = operand_s;
            mem_we_o   = wm_i;
            if (mem_ack_i) begin
               // A store acknowledge carries no read data, so MDR keeps its value.
               mdr_load_s = ~wm_i;
               state_s    = ST_EXEC;
            end else begin
               state_s    = ST_DATA;
            end
         end
         ST_EXEC: begin
            acc_we_o    = wr_i;
            flag_load_s = wf_i;
            pc_load_s   = 1'b1;
            if (jmp_i) begin
               pc_next_s = operand_s;
            end else begin
               // The adder is ADDR_W bits wide, so the PC wraps from all-ones to 0.
               pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
`ifdef AC_SEQ_HALT_EN
            // A taken jump onto itself parks the sequencer.
            if (jmp_i && (operand_s == pc_r)) begin
               state_s = ST_HALT;
            end else begin
               state_s = ST_FETCH;
            end
`else
            state_s = ST_FETCH;
`endif
         end
         ST_HALT: begin
`ifdef AC_SEQ_HALT_EN
            state_s = ST_HALT;
`else
            state_s = ST_FETCH;
`endif
         end
         default: begin
            state_s = ST_FETCH;
         end
      endcase
   end

   // Instruction register: loads on the edge that accepts the fetch ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ir_r <= {DATA_W{1'b0}};
      end else if (ir_load_s) begin
         ir_r <= mem_rdata_i;
      end else begin
         ir_r <= ir_r;
      end
   end

   // Memory data register: loads only on an acknowledged data read.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mdr_r <= {DATA_W{1'b0}};
      end else if (mdr_load_s) begin
         mdr_r <= mem_rdata_i;
      end else begin
         mdr_r <= mdr_r;
      end
   end

   // Flag register: written only in EXEC, so jumps see the previous value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flags_r <= 2'b00;
      end else if (flag_load_s) begin
         flags_r <= {alu_c_i, alu_z_i};
      end else begin
         flags_r <= flags_r;
      end
   end

   // Program counter: advances or jumps in EXEC and is otherwise held.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_r <= {ADDR_W{1'b0}};
      end else if (pc_load_s) begin
         pc_r <= pc_next_s;
      end else begin
         pc_r <= pc_r;
      end
   end

endmodule

// File: tb/tb_ac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ac_sequencer
//
// Directed bench for ac_sequencer. The bench provides a small memory model
// with configurable store wait states and a reference control-unit decode.
// Outputs are sampled on the falling edge, and every expected value is
// hand-computed from the program loaded for each scenario.
// ----------------------------------------------------------------------------
module tb_ac_sequencer;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [2:0]        op;
   logic [ADDR_W-1:0] operand;
   logic [1:0]        flags;
   logic              wr;
   logic              wm;
   logic              jmp;
   logic              wf;
   logic              alu_z;
   logic              alu_c;
   logic [DATA_W-1:0] mdr;
   logic              acc_we;
   logic [ADDR_W-1:0] pc;
   logic              halt;

   logic [DATA_W-1:0] mem [0:31];
   int                sta_waits;
   int                wait_ctr;
   int                n_checks;
   int                n_pass;

   ac_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata),
      .op_o        (op),
      .operand_o   (operand),
      .flags_o     (flags),
      .wr_i        (wr),
      .wm_i        (wm),
      .jmp_i       (jmp),
      .wf_i        (wf),
      .alu_z_i     (alu_z),
      .alu_c_i     (alu_c),
      .mdr_o       (mdr),
      .acc_we_o    (acc_we),
      .pc_o        (pc),
      .halt_o      (halt)
   );

   always #5 clk = ~clk;

   // Memory model: stores wait sta_waits cycles, everything else is zero-wait.
   always_comb begin
      mem_ack   = 1'b0;
      mem_rdata = mem[mem_addr];
      if (mem_req && (wait_ctr >= (mem_we ? sta_waits : 0))) begin
         mem_ack = 1'b1;
      end else begin
         mem_ack = 1'b0;
      end
   end

   // Wait-state counter for the memory model.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_ctr <= 0;
      end else if (mem_req && !mem_ack) begin
         wait_ctr <= wait_ctr + 1;
      end else begin
         wait_ctr <= 0;
      end
   end

   // Reference control unit: ADD SUB LDA STA JMP JZ JC LDI.
   always_comb begin
      wr  = 1'b0;
      wm  = 1'b0;
      jmp = 1'b0;
      wf  = 1'b0;
      case (op)
         3'b000, 3'b001: begin wr = 1'b1; wf = 1'b1; end
         3'b010:         wr  = 1'b1;
         3'b011:         wm  = 1'b1;
         3'b100:         jmp = 1'b1;
         3'b101:         jmp = flags[0];
         3'b110:         jmp = flags[1];
         3'b111:         wr  = 1'b1;
         default:        wr  = 1'b0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         mem[i] = 8'hE0;   // LDI 0
      end
   endtask

   // Reset held for one full cycle. It is released on a falling edge, so
   // the cycle that follows is the first FETCH.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req",    {31'd0, mem_req}, 32'd1);
      chk("rst_addr",   {27'd0, mem_addr}, 32'd0);
      chk("rst_we",     {31'd0, mem_we}, 32'd0);
      chk("rst_accwe",  {31'd0, acc_we}, 32'd0);
      chk("rst_halt",   {31'd0, halt}, 32'd0);
      chk("rst_pc",     {27'd0, pc}, 32'd0);
      chk("rst_mdr",    {24'd0, mdr}, 32'd0);
      chk("rst_flags",  {30'd0, flags}, 32'd0);
      chk("rst_op",     {29'd0, op}, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      alu_z     = 1'b0;
      alu_c     = 1'b0;
      sta_waits = 0;
      clear_mem();

      // LDA 5 with zero-wait memory.
      mem[0] = 8'h45;
      mem[5] = 8'h2A;
      do_reset();
      chk("lda_f_req",  {31'd0, mem_req}, 32'd1);
      chk("lda_f_addr", {27'd0, mem_addr}, 32'd0);
      tick();
      chk("lda_d_req",  {31'd0, mem_req}, 32'd0);
      chk("lda_d_op",   {29'd0, op}, 32'd2);
      chk("lda_d_opnd", {27'd0, operand}, 32'd5);
      tick();
      chk("lda_m_addr", {27'd0, mem_addr}, 32'd5);
      chk("lda_m_we",   {31'd0, mem_we}, 32'd0);
      chk("lda_m_req",  {31'd0, mem_req}, 32'd1);
      tick();
      chk("lda_x_mdr",  {24'd0, mdr}, 32'h2A);
      chk("lda_x_accwe",{31'd0, acc_we}, 32'd1);
      tick();
      chk("lda_nf_addr",{27'd0, mem_addr}, 32'd1);
      chk("lda_nf_pc",  {27'd0, pc}, 32'd1);
      chk("lda_nf_accwe",{31'd0, acc_we}, 32'd0);

      // STA 7 with two wait states in DATA.
      clear_mem();
      mem[0] = 8'h67;
      sta_waits = 2;
      do_reset();
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sta_addr",  {27'd0, mem_addr}, 32'd7);
         chk("sta_we",    {31'd0, mem_we}, 32'd1);
         chk("sta_req",   {31'd0, mem_req}, 32'd1);
         chk("sta_accwe", {31'd0, acc_we}, 32'd0);
         chk("sta_ack",   {31'd0, mem_ack}, (i == 2) ? 32'd1 : 32'd0);
      end
      tick();
      chk("sta_x_accwe",{31'd0, acc_we}, 32'd0);
      chk("sta_x_we",   {31'd0, mem_we}, 32'd0);
      chk("sta_x_mdr",  {24'd0, mdr}, 32'd0);
      tick();
      chk("sta_pc",     {27'd0, pc}, 32'd1);
      sta_waits = 0;

      // Flag chain: SUB sets Z, JZ 3 is taken, JC 9 is not.
      clear_mem();
      mem[0] = 8'h22;   // SUB 2
      mem[1] = 8'hA3;   // JZ 3
      mem[3] = 8'hC9;   // JC 9
      alu_z = 1'b1;
      alu_c = 1'b0;
      do_reset();
      tick();
      tick();
      tick();
      chk("sub_x_flags",{30'd0, flags}, 32'd0);
      tick();
      chk("sub_flags",  {30'd0, flags}, 32'd1);
      alu_z = 1'b0;
      alu_c = 1'b1;
      tick();
      tick();
      chk("jz_x_accwe", {31'd0, acc_we}, 32'd0);
      tick();
      chk("jz_pc",      {27'd0, pc}, 32'd3);
      chk("jz_addr",    {27'd0, mem_addr}, 32'd3);
      tick();
      tick();
      tick();
      chk("jc_pc",      {27'd0, pc}, 32'd4);
      chk("jc_flags",   {30'd0, flags}, 32'd1);

      // PC wrap: JMP 31, then LDI at address 31.
      clear_mem();
      mem[0]  = 8'h9F;
      mem[31] = 8'hE1;
      do_reset();
      tick();
      tick();
      tick();
      chk("wrap_pc31",  {27'd0, pc}, 32'd31);
      chk("wrap_addr31",{27'd0, mem_addr}, 32'd31);
      tick();
      tick();
      chk("wrap_accwe", {31'd0, acc_we}, 32'd1);
      tick();
      chk("wrap_pc0",   {27'd0, pc}, 32'd0);
      chk("wrap_addr0", {27'd0, mem_addr}, 32'd0);
      chk("wrap_req",   {31'd0, mem_req}, 32'd1);

      // Asynchronous reset mid-DATA while the data ack is high.
      clear_mem();
      mem[0] = 8'h45;
      mem[5] = 8'h2A;
      do_reset();
      tick();
      tick();
      chk("ar_ack",     {31'd0, mem_ack}, 32'd1);
      chk("ar_addr5",   {27'd0, mem_addr}, 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("ar_req",     {31'd0, mem_req}, 32'd1);
      chk("ar_addr",    {27'd0, mem_addr}, 32'd0);
      chk("ar_op",      {29'd0, op}, 32'd0);
      chk("ar_mdr",     {24'd0, mdr}, 32'd0);
      @(negedge clk);
      chk("ar_mdr_hold",{24'd0, mdr}, 32'd0);
      rst = 1'b0;
      chk("ar_f_req",   {31'd0, mem_req}, 32'd1);
      chk("ar_f_addr",  {27'd0, mem_addr}, 32'd0);
      tick();
      chk("ar_d_mdr",   {24'd0, mdr}, 32'd0);

      // Self-jump: JMP 4 located at address 4.
      clear_mem();
      mem[0] = 8'h84;
      mem[4] = 8'h84;
      do_reset();
      tick();
      tick();
      tick();
      chk("sj_pc4",     {27'd0, pc}, 32'd4);
      chk("sj_halt0",   {31'd0, halt}, 32'd0);
      tick();
      tick();
      tick();
`ifdef AC_SEQ_HALT_EN
      for (int i = 0; i < 3; i++) begin
         chk("sj_halt",  {31'd0, halt}, 32'd1);
         chk("sj_req",   {31'd0, mem_req}, 32'd0);
         chk("sj_pc",    {27'd0, pc}, 32'd4);
         tick();
      end
`else
      for (int i = 0; i < 3; i++) begin
         chk("sj_halt",  {31'd0, halt}, 32'd0);
         chk("sj_req",   {31'd0, mem_req}, 32'd1);
         chk("sj_addr",  {27'd0, mem_addr}, 32'd4);
         tick();
         chk("sj_dec",   {31'd0, mem_req}, 32'd0);
         tick();
         tick();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
